// File: rtl/key_schedule_pkg.sv
// Shared AES constants: round count, FSM encodings, Rcon and the S-box.
package key_schedule_pkg;

  localparam int AES_NR = 10;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry b lives at bit offset 8*(255-b); 255-b is simply ~b.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] lsb;
    lsb = {~b, 3'b000};
    return SBOX_TBL[lsb +: 8];
  endfunction

  // Round constant for rounds 1..10; anything else contributes nothing.
  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/key_schedule_if.sv
// Handshake and key bus between the schedule and the round datapath.
interface key_schedule_if;
  logic         iStart;
  logic [0:127] iKey;
  logic         iNext;
  logic [0:127] oKey;
  logic [3:0]   oRound;
  logic         oValid;
  logic         oLast;

  modport master (output iStart, iKey, iNext,
                  input  oKey, oRound, oValid, oLast);
  modport slave  (input  iStart, iKey, iNext,
                  output oKey, oRound, oValid, oLast);
endinterface

// File: rtl/key_schedule_sub_word.sv
// SubWord: S-box applied independently to each byte lane of a word.
module key_sub_word
  import key_schedule_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int VEC_W     = 8
) (
  input  logic [NUM_LANES-1:0][VEC_W-1:0] din,
  output logic [NUM_LANES-1:0][VEC_W-1:0] dout
);

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign dout[l] = sbox(din[l]);
  end

endmodule

// File: rtl/key_schedule.sv
// AES-128 key expansion: one round key per iNext, computed on the fly
// from the single registered key (no stored expansion).
module key_schedule
  import key_schedule_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic          iClk,
  input  logic          iRst,
  key_schedule_if.slave bus
);

  localparam logic [3:0] LAST = 4'(NR);

  logic [0:127] key_q;
  logic [3:0]   round_q;
  logic         valid_q;
  logic [0:0]   state_q;

  logic [0:31]  w0, w1, w2, w3, rot, sub, tmp, n0, n1, n2, n3;
  logic [3:0]   round_nxt;

  assign {w0, w1, w2, w3} = key_q;
  assign rot       = {w3[8:31], w3[0:7]};
  assign round_nxt = round_q + 4'd1;

  key_sub_word #(.NUM_LANES(4), .VEC_W(8)) u_sub (
    .din  (rot),
    .dout (sub)
  );

  // Next round key: chained XOR across the four words.
  always_comb begin
    tmp = sub ^ {rcon(round_nxt), 24'h000000};
    n0  = w0 ^ tmp;
    n1  = w1 ^ n0;
    n2  = w2 ^ n1;
    n3  = w3 ^ n2;
  end

  // Control and key register; iStart overrides everything, even in RUN.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      round_q <= '0;
      valid_q <= 1'b0;
    end else if (bus.iStart) begin
      state_q <= ST_RUN;
      key_q   <= bus.iKey;
      round_q <= '0;
      valid_q <= 1'b1;
    end else if (state_q == ST_RUN && bus.iNext) begin
      if (round_q < LAST) begin
        key_q   <= {n0, n1, n2, n3};
        round_q <= round_nxt;
      end else begin
        // Final key consumed; key and index stay visible but invalid.
        valid_q <= 1'b0;
        state_q <= ST_IDLE;
      end
    end
  end

  assign bus.oKey   = key_q;
  assign bus.oRound = round_q;
  assign bus.oValid = valid_q;
  assign bus.oLast  = valid_q && (round_q == LAST);

endmodule

// File: tb/tb_key_schedule.sv
// Directed bench for key_schedule: stimulus queues expected outputs per
// cycle, a negedge monitor pops and compares them.
module tb_key_schedule;
  import key_schedule_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  key_schedule_if ks();

  key_schedule #(.NR(10)) dut (
    .iClk (clk),
    .iRst (rst),
    .bus  (ks)
  );

  typedef struct {
    int           cyc;
    logic [127:0] key;
    bit           chk_key;
    logic [3:0]   round;
    bit           valid;
    bit           last;
  } exp_t;

  exp_t exp_q[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  logic [127:0] k1 [0:10];
  localparam logic [127:0] K2_0  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2_10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  // Reference state: which key table is active, index, validity.
  int m_tbl   = 0;
  int m_round = 0;
  bit m_valid = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare everything due for the current cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.cyc < cyc) begin
        total++; bad++;
        $display("FAIL missed: expectation for cycle %0d not checked, now %0d", e.cyc, cyc);
      end else begin
        if (e.chk_key) check("key", ks.oKey, e.key);
        check("round", 128'(ks.oRound), 128'(e.round));
        check("valid", 128'(ks.oValid), 128'(e.valid));
        check("last",  128'(ks.oLast),  128'(e.last));
      end
    end
  end

  function automatic exp_t model_out(input int c);
    exp_t e;
    e.cyc     = c;
    e.round   = 4'(m_round);
    e.valid   = m_valid;
    e.last    = m_valid && m_round == 10;
    e.chk_key = 1'b1;
    e.key     = '0;
    if (m_tbl == 1) e.key = k1[m_round];
    else if (m_tbl == 2) begin
      if (m_round == 0)       e.key = K2_0;
      else if (m_round == 10) e.key = K2_10;
      else                    e.chk_key = 1'b0;
    end
    return e;
  endfunction

  // Drive one cycle of inputs (called just after a rising edge).
  task automatic step(input bit start, input int sel, input bit nxt);
    ks.iStart = start;
    ks.iKey   = start ? ((sel == 2) ? K2_0 : k1[0]) : 128'h0;
    ks.iNext  = nxt;
    if (rst) begin
      m_tbl = 0; m_round = 0; m_valid = 0;
    end else if (start) begin
      m_tbl = sel; m_round = 0; m_valid = 1;
    end else if (m_valid && nxt) begin
      if (m_round < 10) m_round++;
      else m_valid = 0;
    end
    exp_q.push_back(model_out(cyc + 1));
    @(posedge clk); #1;
  endtask

  initial begin
    k1[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    k1[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    k1[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    k1[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    k1[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    k1[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    k1[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    k1[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    k1[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    k1[9]  = 128'hac7766f319fadc2128d12941575c006e;
    k1[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    ks.iStart = 0; ks.iKey = '0; ks.iNext = 0;
    // Reset held, even with iStart requested.
    step(1, 1, 0);
    step(0, 0, 1);
    rst = 0;
    // Idle: iNext ignored.
    step(0, 0, 1);
    step(0, 0, 1);

    // Full schedule with iNext held, then past the end.
    step(1, 1, 0);
    for (int i = 0; i < 14; i++) step(0, 0, 1);

    // Random iNext pattern.
    step(1, 1, 0);
    for (int i = 0; i < 300 && m_valid; i++) step(0, 0, 1'($urandom_range(0, 1)));
    total++;
    if (m_valid) begin
      bad++;
      $display("FAIL random_run: schedule still valid after budget, round %0d", m_round);
    end

    // Restart at round 5 with iNext high: iStart wins.
    step(1, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1);
    step(1, 2, 1);
    for (int i = 0; i < 11; i++) step(0, 0, 1);

    // Async reset between edges at round 3.
    step(1, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1);
    step(0, 0, 0);
    @(negedge clk); #1;
    rst = 1; #1;
    check("rst_key",   ks.oKey,           128'h0);
    check("rst_round", 128'(ks.oRound),   128'h0);
    check("rst_valid", 128'(ks.oValid),   128'h0);
    check("rst_last",  128'(ks.oLast),    128'h0);
    #1 rst = 0;
    m_tbl = 0; m_round = 0; m_valid = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) step(0, 0, 1);
    step(1, 1, 1);
    step(0, 0, 1);

    @(posedge clk); #1;
    @(posedge clk); #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left unchecked", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/key_schedule.md
KEY_SCHEDULE -- requirements
Module: key_schedule

Interface
REQ-001 SHALL have parameter NR, default 10, meaning number of AES-128 rounds (last round-key index).
REQ-002 SHALL have port iClk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-003 SHALL have port iRst, input, 1, meaning asynchronous, active-high reset.
REQ-004 SHALL have port iStart, input, 1, meaning load iKey and begin a new schedule.
REQ-005 SHALL have port iKey, input, [0:127], meaning the cipher key; byte 0 = bits 0:7, word w0 = bits 0:31.
REQ-006 SHALL have port iNext, input, 1, meaning the downstream round consumes oKey this cycle; advance to the next round key.
REQ-007 SHALL have port oKey, output, [0:127], meaning the current round key, registered, same bit/byte order as iKey.
REQ-008 SHALL have port oRound, output, 4, meaning the index of the round key on oKey (0..NR).
REQ-009 SHALL have port oValid, output, 1, meaning oKey/oRound are valid.
REQ-010 SHALL have port oLast, output, 1, meaning oValid and oRound == NR.

Function
REQ-011 SHALL implement FSM with states IDLE and RUN only.
REQ-012 SHALL, in IDLE with iStart=1, register oKey<=iKey, oRound<=0, oValid<=1, and enter RUN next cycle; 1-cycle latency from iStart to round-0 key.
REQ-013 SHALL, in RUN with iNext=1 and oRound<NR, register the next round key, incrementing oRound by 1; one key per cycle with iNext held high.
REQ-014 SHALL compute the next key as: temp = SubWord(RotWord(w3)) XOR {Rcon[oRound+1],8'h00,8'h00,8'h00}; w0'=w0^temp; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.
REQ-015 SHALL use Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36 (hex).
REQ-016 SHALL hold oKey, oRound, oValid unchanged in RUN while iNext=0.
REQ-017 SHALL, in RUN with iNext=1 and oRound==NR, clear oValid, return to IDLE; oKey and oRound retain last values.
REQ-018 SHALL give iStart priority over iNext in any state: iStart=1 in RUN restarts at round 0 with the new iKey, ignoring iNext that cycle.
REQ-019 SHALL ignore iNext in IDLE (no state or output change).
REQ-020 SHALL derive oLast combinationally from registered oValid and oRound only.

Reset
REQ-021 SHALL, on iRst=1, asynchronously force state=IDLE, oKey=128'd0, oRound=0, oValid=0, oLast=0.
REQ-022 SHALL, when iRst asserts mid-schedule, abandon the schedule; after release, remain IDLE until iStart.
REQ-023 SHALL begin acting on iStart no earlier than the first rising edge after iRst deasserts.

Structure
REQ-024 SHALL take the Rcon table, NR default, and FSM state encodings from a shared AES package used by all round-stage blocks.
REQ-025 SHALL instantiate one sub-module, key_sub_word, applying the AES S-box to the four bytes of a 32-bit word (combinational); S-box content matches the one used by the round datapath.
REQ-026 SHALL contain exactly one 128-bit key register, 4-bit round counter, and 1-bit state register; no multi-cycle key storage.

Verification
REQ-027 SHALL verify: iStart with key 2b7e151628aed2a6abf7158809cf4f3c -> next cycle oKey=2b7e1516..09cf4f3c, oRound=0, oValid=1.
REQ-028 SHALL verify: iNext held high after that start -> round 1 a0fafe1788542cb123a339392a6c7605, round 2 f2c295f27a96b9435935807a7359f67f, round 10 d014f9a8c9ee2589e13f0cc8b6630ca6 with oLast=1, on consecutive cycles.
REQ-029 SHALL verify: iNext at round 10 -> oValid=0, oLast=0 next cycle; further iNext causes no change.
REQ-030 SHALL verify: iNext toggled randomly -> oRound advances only on iNext cycles, keys match REQ-028 sequence in order.
REQ-031 SHALL verify: iStart with key 000102030405060708090a0b0c0d0e0f asserted at round 5 with iNext=1 -> next cycle oRound=0, oKey=000102..0e0f; round 10 later = 13111d7fe3944a17f307a78b4d2b30c5.
REQ-032 SHALL verify: iRst pulsed asynchronously (between clock edges) at round 3 -> outputs zero immediately; no activity until fresh iStart.
